everloop_rx: RTL and testbench
==============================

Name: everloop_rx

Overview:
- Receiver for the one-wire WS2812-style everloop LED stream, i.e. the far end of the line driven by the everloop transmitter.
- Samples the serial line, classifies each bit by its high-pulse width, and assembles bytes MSB-first.
- Stores one frame of bytes in an internal dual-port buffer and exposes the buffer plus status and control registers as a Wishbone slave.
- Used for loopback self-test of the everloop path and for monitoring the everloop feedback pin.

Parameters:
ADR_WIDTH, 11, byte-address width of the frame buffer (depth 2^ADR_WIDTH bytes).
T1H_MIN, 60, high-pulse length in clk cycles at or above which a bit decodes as 1 (0.6 us at 100 MHz).
MAX_HIGH, 200, high-pulse length in clk cycles that flags a stuck-high error.
RESET_CYCLES, 5000, low time in clk cycles that terminates a frame (50 us at 100 MHz).
CNT_WIDTH, 16, width of the pulse and idle counters; must hold RESET_CYCLES.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset
wb_stb_i  input  1  Wishbone strobe
wb_cyc_i  input  1  Wishbone cycle
wb_we_i  input  1  Wishbone write enable
wb_adr_i  input  32  Wishbone word address
wb_sel_i  input  4  byte selects; ignored, full-word access only
wb_dat_i  input  32  write data
wb_dat_o  output  32  read data
wb_ack_o  output  1  Wishbone acknowledge
led_fb  input  1  asynchronous serial LED line to decode

Behaviour:
- Reset (reset==0 at a clk edge):
  - wb_ack_o=0, wb_dat_o=0.
  - FSM goes to SYNC; wr_ptr=0, bit_cnt=0.
  - frame_cnt=0, last_len=0; error flags overflow, frag and stuck cleared.
  - Buffer contents are undefined.
  - Reset mid-frame discards the partial frame.
- Input conditioning:
  - led_fb passes through a 2-flop synchronizer, then a third flop for edge detection.
  - All timing is measured on the synchronized signal; this adds 2 cycles of fixed latency.
- FSM states:
  - SYNC: count consecutive low cycles. After RESET_CYCLES, go to IDLE. Any high sample restarts the count.
  - IDLE: rising edge -> HIGH with hi_cnt=1.
  - HIGH: increment hi_cnt each cycle.
    - On a falling edge: bit = (hi_cnt >= T1H_MIN), shift it into the byte register, then go to LOW with lo_cnt=1.
    - If hi_cnt reaches MAX_HIGH: set stuck, drop the partial byte and go to SYNC.
  - LOW: increment lo_cnt.
    - Rising edge -> HIGH with hi_cnt=1.
    - lo_cnt == RESET_CYCLES -> end of frame, then IDLE.
- Byte assembly:
  - The 8th bit completes a byte. In the same cycle the byte is written to buffer[wr_ptr] and wr_ptr increments.
  - If wr_ptr == 2^ADR_WIDTH, set overflow and drop further bytes of the frame. No wrap-around.
- End of frame:
  - If bit_cnt != 0, set frag and discard the partial bits.
  - last_len <= wr_ptr (saturates at 2^ADR_WIDTH).
  - frame_cnt increments, wrapping at 16 bits.
  - wr_ptr=0, bit_cnt=0.
  - A frame of zero bytes (idle line) does not increment frame_cnt.
- Buffer layout:
  - Word w holds bytes 4w..4w+3, with byte 4w in bits [7:0] and byte 4w+3 in [31:24].
  - Implemented as simple dual-port RAM: decoder writes bytes, Wishbone reads words.
- Wishbone address map:
  - wb_adr_i[12]=0: buffer word at index wb_adr_i[ADR_WIDTH-3:0]. Read-only; writes are acked and ignored.
  - wb_adr_i[12]=1, index 0, STATUS (read): [31:16]=frame_cnt, [2]=stuck, [1]=frag, [0]=overflow, [3]=busy (FSM in HIGH or LOW).
  - wb_adr_i[12]=1, index 1, LAST_LEN (read): last_len zero-extended.
  - wb_adr_i[12]=1, index 2, CTRL (write): bit0=1 clears the three error flags. Reads return 0.
  - Unmapped addresses read 0.
- Wishbone handshake:
  - wb_ack_o asserts exactly one cycle after stb&cyc is first seen, with wb_dat_o valid in that same cycle.
  - ack deasserts the following cycle. Back-to-back transfers therefore take 2 cycles each.
  - If the master drops stb before ack, no ack is issued.
- Simultaneous events:
  - A buffer read of a byte being written in the same cycle returns the old value.
  - A CTRL clear in the same cycle as a flag set leaves the flag set (set wins).
  - A STATUS read on the frame-end cycle returns the pre-update frame_cnt.

Test Plan:
- Reset, then hold led_fb low for 5000 cycles and send bytes 0xA5,0x3C (bit 1 = 80 high/45 low, bit 0 = 40 high/85 low), then low for 5000 cycles -> STATUS[31:16]=1, LAST_LEN=2, buffer word0[15:0]=0x3CA5, error flags 0.
- Pulse-width boundary: high pulses of exactly 59 and 60 cycles -> decode as 0 and 1 respectively.
- Send 10 bits, then frame gap -> frag=1, LAST_LEN=1, byte0 equals the first 8 bits. Then write CTRL=1 -> frag=0.
- Set ADR_WIDTH=4 and send 17 bytes -> LAST_LEN=16, overflow=1, buffer holds the first 16 bytes only.
- Hold led_fb high for 200 cycles mid-frame -> stuck=1, FSM re-enters SYNC, and the next valid frame decodes correctly.
- Assert reset for 1 cycle mid-byte, then send one full frame of 0xFF -> frame_cnt=1, LAST_LEN=1, word0[7:0]=0xFF. Check ack timing: one cycle of ack per access.

Source files
------------

// File: rtl/everloop_rx.sv
// everloop_rx: decodes a WS2812-style one-wire LED stream into a byte frame buffer
// and exposes the buffer plus status/control registers through a Wishbone slave.
module everloop_rx #(
    parameter int ADR_WIDTH    = 11,
    parameter int T1H_MIN      = 60,
    parameter int MAX_HIGH     = 200,
    parameter int RESET_CYCLES = 5000,
    parameter int CNT_WIDTH    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    input  logic        led_fb
);
    localparam int WA_W  = ADR_WIDTH - 2;
    localparam int WORDS = 1 << WA_W;
    localparam logic [CNT_WIDTH-1:0] RST_C  = CNT_WIDTH'(RESET_CYCLES);
    localparam logic [CNT_WIDTH-1:0] T1H_C  = CNT_WIDTH'(T1H_MIN);
    localparam logic [CNT_WIDTH-1:0] MAXH_C = CNT_WIDTH'(MAX_HIGH);
    localparam logic [CNT_WIDTH-1:0] ONE_C  = CNT_WIDTH'(1);

    typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
    logic [7:0]           shift_q, shift_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic [ADR_WIDTH:0]   wr_ptr_q, wr_ptr_d, last_len_q, last_len_d;
    logic [15:0]          frame_cnt_q, frame_cnt_d;
    logic                 ovf_q, ovf_d, frag_q, frag_d, stuck_q, stuck_d;
    logic                 sync1_q, sync2_q, prev_q;
    logic                 ack_q, ack_d, buf_sel_q, buf_sel_d;
    logic [31:0]          reg_dat_q, reg_dat_d, rd_word_q;
    logic                 rise, fall, bit_v, busy;
    logic                 req, top_ok, is_buf, is_reg, clr;
    logic                 ovf_set, frag_set, stuck_set;
    logic                 mem_we;
    logic [7:0]           mem_wdata;
    logic [31:0]          mem [WORDS];
    logic                 unused_bits;

    assign rise    = sync2_q & ~prev_q;
    assign fall    = ~sync2_q & prev_q;
    assign cnt_inc = cnt_q + ONE_C;
    assign bit_v   = (cnt_q >= T1H_C);
    assign busy    = (state_q == HIGH) || (state_q == LOW);

    assign req    = wb_stb_i & wb_cyc_i & ~ack_q;
    assign top_ok = (wb_adr_i[31:13] == '0);
    assign is_buf = top_ok & ~wb_adr_i[12] & (wb_adr_i[11:WA_W] == '0);
    assign is_reg = top_ok & wb_adr_i[12];
    assign clr    = req & wb_we_i & is_reg & (wb_adr_i[11:0] == 12'd2) & wb_dat_i[0];

    assign unused_bits = ^{wb_sel_i, wb_dat_i[31:1]};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        wr_ptr_d    = wr_ptr_q;
        last_len_d  = last_len_q;
        frame_cnt_d = frame_cnt_q;
        ovf_set     = 1'b0;
        frag_set    = 1'b0;
        stuck_set   = 1'b0;
        mem_we      = 1'b0;
        mem_wdata   = {shift_q[6:0], bit_v};
        case (state_q)
            SYNC: begin
                if (sync2_q) begin
                    cnt_d = '0;
                end else if (cnt_inc == RST_C) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            IDLE: begin
                if (rise) begin
                    cnt_d   = ONE_C;
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (fall) begin
                    shift_d   = {shift_q[6:0], bit_v};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        // A full buffer drops the byte instead of wrapping over frame start
                        if (wr_ptr_q[ADR_WIDTH]) begin
                            ovf_set = 1'b1;
                        end else begin
                            mem_we   = 1'b1;
                            wr_ptr_d = wr_ptr_q + 1'b1;
                        end
                    end
                    cnt_d   = ONE_C;
                    state_d = LOW;
                end else if (cnt_inc >= MAXH_C) begin
                    stuck_set = 1'b1;
                    bit_cnt_d = '0;
                    wr_ptr_d  = '0;
                    cnt_d     = '0;
                    state_d   = SYNC;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            LOW: begin
                if (rise) begin
                    cnt_d   = ONE_C;
                    state_d = HIGH;
                end else if (cnt_inc == RST_C) begin
                    frag_set   = (bit_cnt_q != 3'd0);
                    last_len_d = wr_ptr_q;
                    if (wr_ptr_q != '0) frame_cnt_d = frame_cnt_q + 16'd1;
                    wr_ptr_d   = '0;
                    bit_cnt_d  = '0;
                    cnt_d      = '0;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = SYNC;
        endcase

        // Sets are OR'd after the clear so a coincident set survives
        ovf_d   = (ovf_q & ~clr) | ovf_set;
        frag_d  = (frag_q & ~clr) | frag_set;
        stuck_d = (stuck_q & ~clr) | stuck_set;

        ack_d     = req;
        buf_sel_d = req & ~wb_we_i & is_buf;
        reg_dat_d = '0;
        if (req && !wb_we_i && is_reg) begin
            case (wb_adr_i[11:0])
                12'd0:   reg_dat_d = {frame_cnt_q, 12'd0, busy, stuck_q, frag_q, ovf_q};
                12'd1:   reg_dat_d = 32'(last_len_q);
                default: reg_dat_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            prev_q      <= 1'b0;
            state_q     <= SYNC;
            cnt_q       <= '0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            wr_ptr_q    <= '0;
            last_len_q  <= '0;
            frame_cnt_q <= '0;
            ovf_q       <= 1'b0;
            frag_q      <= 1'b0;
            stuck_q     <= 1'b0;
            ack_q       <= 1'b0;
            buf_sel_q   <= 1'b0;
            reg_dat_q   <= '0;
        end else begin
            sync1_q     <= led_fb;
            sync2_q     <= sync1_q;
            prev_q      <= sync2_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            last_len_q  <= last_len_d;
            frame_cnt_q <= frame_cnt_d;
            ovf_q       <= ovf_d;
            frag_q      <= frag_d;
            stuck_q     <= stuck_d;
            ack_q       <= ack_d;
            buf_sel_q   <= buf_sel_d;
            reg_dat_q   <= reg_dat_d;
        end
    end

    // Byte-write / word-read RAM; a same-cycle read of the written word sees the old data
    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_ptr_q[ADR_WIDTH-1:2]][{wr_ptr_q[1:0], 3'b000} +: 8] <= mem_wdata;
        rd_word_q <= mem[wb_adr_i[WA_W-1:0]];
    end

    assign wb_ack_o = ack_q;
    assign wb_dat_o = buf_sel_q ? rd_word_q : reg_dat_q;
endmodule

// File: tb/tb_everloop_rx.sv
// Randomized bench for everloop_rx: frames are scored by a bit-list model and
// Wishbone read data is checked by a scoreboard monitor on every ack.
module tb_everloop_rx;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;
    localparam int RC    = 1500;
    localparam int T1H   = 60;
    localparam logic [31:0] STATUS = 32'h1000, LASTLEN = 32'h1001, CTRL = 32'h1002;

    logic clk = 1'b0, reset = 1'b0;
    logic stb = 1'b0, cyc = 1'b0, we = 1'b0, led = 1'b0;
    logic [31:0] adr = '0, wdat = '0, rdat;
    logic [3:0] sel = 4'hF;
    logic ack;

    always #5 clk = ~clk;

    everloop_rx #(.ADR_WIDTH(AW), .RESET_CYCLES(RC)) dut (
        .clk(clk), .reset(reset), .wb_stb_i(stb), .wb_cyc_i(cyc), .wb_we_i(we),
        .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(wdat), .wb_dat_o(rdat),
        .wb_ack_o(ack), .led_fb(led)
    );

    int vectors = 0, miscompares = 0;

    typedef struct {
        string       name;
        logic [31:0] exp;
        logic [31:0] mask;
    } sb_t;
    sb_t sb_q[$];
    sb_t mon_e;

    int m_frame_cnt = 0, m_last_len = 0;
    bit m_ovf = 0, m_frag = 0, m_stuck = 0;
    logic [7:0] m_buf [DEPTH];
    bit m_valid [DEPTH];
    int hi_q[$], lo_q[$];

    always @(negedge clk) begin
        if (ack) begin
            if (sb_q.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL unexpected_ack: ack with no access pending, data %h", rdat);
            end else begin
                mon_e = sb_q.pop_front();
                if (mon_e.mask != 0) begin
                    vectors++;
                    if ((rdat & mon_e.mask) !== (mon_e.exp & mon_e.mask)) begin
                        miscompares++;
                        $display("FAIL %s: got %h want %h (mask %h)", mon_e.name, rdat, mon_e.exp, mon_e.mask);
                    end
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    task automatic wb_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                             input string name, input logic [31:0] exp, input logic [31:0] mask);
        @(posedge clk); #1;
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; wdat = d;
        sb_q.push_back('{name, exp, mask});
        @(posedge clk); #1;
        check({name, "_ack_hi"}, 32'(ack), 32'd1);
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        check({name, "_ack_lo"}, 32'(ack), 32'd0);
    endtask

    task automatic rd(input logic [31:0] a, input string name, input logic [31:0] exp, input logic [31:0] mask);
        wb_access(1'b0, a, '0, name, exp, mask);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        wb_access(1'b1, a, d, "write", '0, '0);
    endtask

    function automatic logic [31:0] exp_status();
        return {16'(m_frame_cnt), 12'd0, 1'b0, m_stuck, m_frag, m_ovf};
    endfunction

    task automatic check_regs(input string tag);
        rd(STATUS, {tag, "_status"}, exp_status(), 32'hFFFF_FFFF);
        rd(LASTLEN, {tag, "_lastlen"}, 32'(m_last_len), 32'hFFFF_FFFF);
    endtask

    task automatic check_buffer(input string tag);
        for (int w = 0; w < DEPTH / 4; w++) begin
            logic [31:0] e, m;
            e = '0; m = '0;
            for (int k = 0; k < 4; k++) begin
                if (m_valid[4 * w + k]) begin
                    e[8 * k +: 8] = m_buf[4 * w + k];
                    m[8 * k +: 8] = 8'hFF;
                end
            end
            if (m != 0) rd(32'(w), $sformatf("%s_word%0d", tag, w), e, m);
        end
    endtask

    function automatic void add_bit(input int hi, input int lo);
        hi_q.push_back(hi);
        lo_q.push_back(lo);
    endfunction

    function automatic void add_rand_bit(input bit b);
        add_bit(b ? int'($urandom_range(150, T1H)) : int'($urandom_range(T1H - 1, 8)),
                int'($urandom_range(100, 20)));
    endfunction

    function automatic void add_rand_byte();
        logic [7:0] v;
        v = 8'($urandom);
        for (int i = 7; i >= 0; i--) add_rand_bit(v[i]);
    endfunction

    // Reference: bits from pulse widths, MSB-first bytes, buffer capped at DEPTH
    function automatic void model_frame();
        int nbits, nbytes;
        logic [7:0] v;
        nbits  = hi_q.size();
        nbytes = nbits / 8;
        for (int b = 0; b < nbytes; b++) begin
            v = '0;
            for (int i = 0; i < 8; i++) v = {v[6:0], (hi_q[8 * b + i] >= T1H)};
            if (b < DEPTH) begin
                m_buf[b] = v;
                m_valid[b] = 1'b1;
            end else begin
                m_ovf = 1'b1;
            end
        end
        if (nbits % 8 != 0) m_frag = 1'b1;
        m_last_len = (nbytes > DEPTH) ? DEPTH : nbytes;
        if (nbytes > 0) m_frame_cnt = (m_frame_cnt + 1) & 16'hFFFF;
    endfunction

    task automatic line_hold(input logic v, input int n);
        led = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits();
        for (int i = 0; i < hi_q.size(); i++) begin
            line_hold(1'b1, hi_q[i]);
            line_hold(1'b0, lo_q[i]);
        end
    endtask

    task automatic send_frame();
        send_bits();
        line_hold(1'b0, RC + 20);
        model_frame();
        hi_q.delete();
        lo_q.delete();
    endtask

    task automatic model_reset();
        m_frame_cnt = 0; m_last_len = 0;
        m_ovf = 0; m_frag = 0; m_stuck = 0;
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
    endtask

    initial begin
        logic [7:0] fixed_bytes [2];
        fixed_bytes[0] = 8'hA5;
        fixed_bytes[1] = 8'h3C;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check("reset_ack", 32'(ack), 32'd0);
        check("reset_dat", rdat, 32'd0);
        reset = 1'b1;
        check_regs("reset");

        // Basic frame with the nominal pulse timing
        line_hold(1'b0, RC + 20);
        for (int b = 0; b < 2; b++)
            for (int i = 7; i >= 0; i--)
                add_bit(fixed_bytes[b][i] ? 80 : 40, fixed_bytes[b][i] ? 45 : 85);
        send_frame();
        check_regs("basic");
        check_buffer("basic");

        // Threshold boundary: 59 decodes as 0, 60 as 1
        add_bit(59, 60);
        add_bit(60, 60);
        for (int i = 0; i < 6; i++) add_rand_bit(1'($urandom));
        send_frame();
        check_regs("boundary");
        check_buffer("boundary");

        // Fragment: 10 bits leaves a partial byte
        for (int i = 0; i < 10; i++) add_rand_bit(1'($urandom));
        send_frame();
        check_regs("frag");
        check_buffer("frag");
        wr(CTRL, 32'd1);
        m_ovf = 0; m_frag = 0; m_stuck = 0;
        rd(STATUS, "frag_clear", exp_status(), 32'hFFFF_FFFF);

        // Overflow: one byte more than the buffer holds
        for (int i = 0; i < DEPTH + 1; i++) add_rand_byte();
        send_frame();
        check_regs("ovf");
        check_buffer("ovf");
        wr(CTRL, 32'd1);
        m_ovf = 0; m_frag = 0; m_stuck = 0;

        // Randomized frames
        for (int f = 0; f < 3; f++) begin
            int nb;
            nb = int'($urandom_range(4, 1));
            for (int i = 0; i < nb; i++) add_rand_byte();
            send_frame();
            check_regs($sformatf("rand%0d", f));
            check_buffer($sformatf("rand%0d", f));
        end

        // Stuck-high mid-frame, then recovery
        for (int i = 0; i < 3; i++) add_rand_bit(1'($urandom));
        send_bits();
        hi_q.delete();
        lo_q.delete();
        line_hold(1'b1, 250);
        m_stuck = 1'b1;
        rd(STATUS, "stuck_hold", exp_status(), 32'hFFFF_FFFF);
        line_hold(1'b0, RC + 20);
        add_rand_byte();
        add_rand_byte();
        send_frame();
        check_regs("after_stuck");
        check_buffer("after_stuck");

        // Unmapped addresses, CTRL readback and ignored buffer writes
        rd(32'h0000_1003, "unmapped_reg", 32'd0, 32'hFFFF_FFFF);
        rd(32'h0000_2000, "unmapped_hi", 32'd0, 32'hFFFF_FFFF);
        rd(32'h0000_0004, "unmapped_buf", 32'd0, 32'hFFFF_FFFF);
        rd(CTRL, "ctrl_read", 32'd0, 32'hFFFF_FFFF);
        wr(32'h0, 32'hDEAD_BEEF);
        check_buffer("buf_write_ignored");

        // Back-to-back: stb held for three edges acks on the 1st and 3rd only
        @(posedge clk); #1;
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = STATUS;
        sb_q.push_back('{"b2b_first", exp_status(), 32'hFFFF_FFFF});
        sb_q.push_back('{"b2b_second", exp_status(), 32'hFFFF_FFFF});
        @(posedge clk); #1;
        check("b2b_ack1", 32'(ack), 32'd1);
        @(posedge clk); #1;
        check("b2b_ack2", 32'(ack), 32'd0);
        @(posedge clk); #1;
        check("b2b_ack3", 32'(ack), 32'd1);
        stb = 1'b0; cyc = 1'b0;
        @(posedge clk); #1;
        check("b2b_ack4", 32'(ack), 32'd0);

        // Reset mid-byte discards everything, then a fresh 0xFF frame
        for (int i = 0; i < 4; i++) add_rand_bit(1'($urandom));
        send_bits();
        hi_q.delete();
        lo_q.delete();
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        model_reset();
        check("midreset_ack", 32'(ack), 32'd0);
        line_hold(1'b0, RC + 20);
        for (int i = 0; i < 8; i++) add_rand_bit(1'b1);
        send_frame();
        check_regs("post_reset");
        check_buffer("post_reset");

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
